nibble_serial_adder_ctrl: RTL
=============================

NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit nibbles per operand; operand width W = 4*NIBBLES.
REQ-002 Parameter CLA_LAT, default 1: cycles from the cycle cla_a/cla_b/cla_c are presented to the cycle cla_s/cla_co are valid; legal range 0..7.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request: capture a_in, b_in, c_in and begin an add.
REQ-006 a_in  input  W  operand A.
REQ-007 b_in  input  W  operand B.
REQ-008 c_in  input  1  carry-in of the full-width add.
REQ-009 busy  output  1  high while an add is in progress.
REQ-010 done  output  1  one-cycle pulse: sum/c_out valid.
REQ-011 sum  output  W  result, held until the next accepted start.
REQ-012 c_out  output  1  final carry, held with sum.
REQ-013 cla_a  output  4  current A nibble to the 4-bit CLA stage.
REQ-014 cla_b  output  4  current B nibble to the CLA stage.
REQ-015 cla_c  output  1  current carry to the CLA stage.
REQ-016 cla_s  input  4  sum nibble returned by the CLA stage.
REQ-017 cla_co  input  1  carry returned by the CLA stage.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-019 IDLE: start=1 -> capture a_in/b_in/c_in, nibble index k=0, drive nibble 0 (bits 3:0) and c_in on cla_*, go ISSUE.
REQ-020 ISSUE lasts one cycle (nibble k presented); then WAIT with wait counter = 0; if CLA_LAT=0, ISSUE samples cla_s/cla_co itself at end of its cycle and skips WAIT.
REQ-021 WAIT: counter increments each cycle; at end of the cycle where counter = CLA_LAT-1, sample cla_s into sum nibble k and cla_co into carry register.
REQ-022 After sample: if k < NIBBLES-1 -> k+1, drive nibble k+1 with the sampled carry on cla_c, go ISSUE; else c_out <= sampled carry, go DONE.
REQ-023 Each nibble costs CLA_LAT+1 cycles; start edge to done-high = NIBBLES*(CLA_LAT+1)+1 cycles (9 for defaults).
REQ-024 busy = 1 in ISSUE and WAIT, 0 in IDLE and DONE.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; start=1 in DONE is accepted exactly as in IDLE (back-to-back).
REQ-026 start while busy is ignored; captured operands unaffected.
REQ-027 Operand inputs are sampled only on an accepted start; later changes have no effect on the running add.
REQ-028 sum/c_out update nibble-by-nibble internally but are presented to sum/c_out outputs only on entering DONE; otherwise hold previous result.
REQ-029 cla_a/cla_b/cla_c hold their last value in WAIT, DONE and IDLE.

Reset
REQ-030 reset=1 at a rising edge -> IDLE; busy, done, c_out, cla_c = 0; sum, cla_a, cla_b = 0; counters and k = 0.
REQ-031 reset overrides start and any in-progress add; no done pulse is produced for an aborted add.
REQ-032 First start is accepted on the first edge with reset=0.

Verification (bench pairs the block with a behavioural 4-bit CLA of matching latency; run CLA_LAT=1 and 2)
REQ-033 a_in=0xABCD, b_in=0x1234, c_in=0, start 1 cycle -> done 9 cycles later (CLA_LAT=1), sum=0xBE01, c_out=0.
REQ-034 a_in=0xFFFF, b_in=0x0001, c_in=0 -> carry ripples all nibbles: cla_c=1 on nibbles 1..3, sum=0x0000, c_out=1.
REQ-035 a_in=0xFFFF, b_in=0xFFFF, c_in=1 -> sum=0xFFFF, c_out=1; with CLA_LAT=2 done at cycle 13.
REQ-036 start pulsed again 3 cycles into an add with different operands -> ignored; result matches first operands, single done pulse.
REQ-037 reset asserted mid-add (cycle 4) -> next cycle busy=0, sum=0, c_out=0, no done; new start then completes correctly.
REQ-038 start held high through done -> second add begins in DONE cycle; two done pulses spaced NIBBLES*(CLA_LAT+1)+1 cycles, both results correct.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder controller: streams W-bit operands one nibble at a time
// through an external 4-bit CLA stage of fixed latency and assembles the result.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4,
    parameter int CLA_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a_in,
    input  logic [4*NIBBLES-1:0]   b_in,
    input  logic                   c_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   c_out,
    output logic [3:0]             cla_a,
    output logic [3:0]             cla_b,
    output logic                   cla_c,
    input  logic [3:0]             cla_s,
    input  logic                   cla_co
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [2:0] LAST_CNT = (CLA_LAT == 0) ? 3'd0 : 3'(CLA_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic [KW-1:0]   k;
    logic [2:0]      cnt;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    acc;

    logic            accept;
    logic            sample;
    logic            last;
    logic [W-1:0]    a_next;
    logic [W-1:0]    b_next;
    logic [W-1:0]    acc_next;
    logic [W+3:0]    acc_ext;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: next_state = accept ? S_ISSUE : S_IDLE;
            S_ISSUE, S_WAIT: begin
                if (sample) next_state = last ? S_DONE : S_ISSUE;
                else        next_state = S_WAIT;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Control decode; operand registers shift right so the live nibble sits at [3:0],
    // and result nibbles shift in from the top so nibble 0 lands at [3:0] at the end.
    always_comb begin
        accept   = start && (state == S_IDLE || state == S_DONE);
        sample   = (state == S_ISSUE && CLA_LAT == 0) ||
                   (state == S_WAIT && cnt == LAST_CNT);
        last     = (k == KW'(NIBBLES - 1));
        a_next   = a_sh >> 4;
        b_next   = b_sh >> 4;
        acc_ext  = {cla_s, acc};
        acc_next = acc_ext[W+3:4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            cla_a <= '0;
            cla_b <= '0;
            cla_c <= 1'b0;
            k     <= '0;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
        end else begin
            busy <= (next_state == S_ISSUE) || (next_state == S_WAIT);
            done <= (next_state == S_DONE);
            if (accept) begin
                a_sh  <= a_in;
                b_sh  <= b_in;
                cla_a <= a_in[3:0];
                cla_b <= b_in[3:0];
                cla_c <= c_in;
                k     <= '0;
                cnt   <= '0;
            end else begin
                if (state == S_ISSUE)     cnt <= '0;
                else if (state == S_WAIT) cnt <= cnt + 3'd1;
                if (sample) begin
                    acc <= acc_next;
                    if (last) begin
                        sum   <= acc_next;
                        c_out <= cla_co;
                    end else begin
                        k     <= k + 1'b1;
                        a_sh  <= a_next;
                        b_sh  <= b_next;
                        cla_a <= a_next[3:0];
                        cla_b <= b_next[3:0];
                        cla_c <= cla_co;
                    end
                end
            end
        end
    end

endmodule
